// File: rtl/instr_mem_dbg_burst_if.sv
// Debug-port bundle for instr_mem_dbg_burst: command, write-data and read-response channels.
// master = UART command decoder side, slave = memory side.
interface instr_mem_dbg_burst_if #(
    parameter int unsigned DBG_ADDR_W = 9,
    parameter int unsigned LEN_W      = 8
);
    logic                    dbg_cmd_valid;
    logic                    dbg_cmd_ready;
    logic                    dbg_cmd_write;
    logic [DBG_ADDR_W-1:0]   dbg_cmd_addr;
    logic [LEN_W-1:0]        dbg_cmd_len;
    logic                    dbg_wdata_valid;
    logic                    dbg_wdata_ready;
    logic [31:0]             dbg_wdata;
    logic                    dbg_rsp_valid;
    logic                    dbg_rsp_ready;
    logic [DBG_ADDR_W+32:0]  dbg_rsp_data;
    logic                    dbg_busy;
    logic                    dbg_err;

    modport master (
        output dbg_cmd_valid, dbg_cmd_write, dbg_cmd_addr, dbg_cmd_len,
        output dbg_wdata_valid, dbg_wdata, dbg_rsp_ready,
        input  dbg_cmd_ready, dbg_wdata_ready, dbg_rsp_valid, dbg_rsp_data, dbg_busy, dbg_err
    );

    modport slave (
        input  dbg_cmd_valid, dbg_cmd_write, dbg_cmd_addr, dbg_cmd_len,
        input  dbg_wdata_valid, dbg_wdata, dbg_rsp_ready,
        output dbg_cmd_ready, dbg_wdata_ready, dbg_rsp_valid, dbg_rsp_data, dbg_busy, dbg_err
    );
endinterface

// File: rtl/instr_mem_dbg_burst.sv
// Instruction memory: registered fetch port with stall/flush/fault, plus burst debug port.
// Define INSTR_MEM_PARITY_EN to store and check an even-parity bit per word.
module instr_mem_dbg_burst #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DBG_ADDR_W = 9,
    parameter int unsigned LEN_W      = 8,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [31:0]                 pc,
    output logic [31:0]                 instr,
    output logic                        fetch_fault,
    instr_mem_dbg_burst_if.slave        dbg
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] PcLimit = 32'(DEPTH * 4);
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MW = 33;
    localparam logic [MW-1:0] MemInit = {^NOP_WORD, NOP_WORD};
`else
    localparam int unsigned MW = 32;
    localparam logic [MW-1:0] MemInit = NOP_WORD;
`endif

    typedef enum logic [1:0] {StIdle, StWr, StRdRd, StRdRsp} state_e;

    // Contents survive reset; only the time-zero image is NOP_WORD.
    logic [MW-1:0] mem_q [DEPTH] = '{default: MemInit};

    state_e                 st_q, st_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [DBG_ADDR_W+32:0] rsp_data_q, rsp_data_d;
    logic                   err_q, err_d;
    logic                   live_q;
    logic                   mem_we;
    logic [MW-1:0]          wr_word, rd_word, fetch_word;
    logic                   rd_par_err, fetch_par_err;
    logic                   pc_bad, cmd_bad;

    assign rd_word    = mem_q[addr_q];
    assign fetch_word = mem_q[pc[AW+1:2]];
    assign pc_bad     = (pc[1:0] != 2'b00) || (pc >= PcLimit);
    assign cmd_bad    = {1'b0, dbg.dbg_cmd_addr} >= (DBG_ADDR_W+1)'(DEPTH);

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word       = {^dbg.dbg_wdata, dbg.dbg_wdata};
    assign rd_par_err    = ^rd_word;
    assign fetch_par_err = ^fetch_word;
`else
    assign wr_word       = dbg.dbg_wdata;
    assign rd_par_err    = 1'b0;
    assign fetch_par_err = 1'b0;
`endif

    // Fetch reads the pre-write value when a debug write hits the same word.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr       <= NOP_WORD;
            fetch_fault <= 1'b0;
        end else if (flush) begin
            instr       <= NOP_WORD;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            if (pc_bad || fetch_par_err) begin
                instr       <= NOP_WORD;
                fetch_fault <= 1'b1;
            end else begin
                instr       <= fetch_word[31:0];
                fetch_fault <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            live_q     <= 1'b1;
        end
    end

    always_comb begin
        st_d                = st_q;
        addr_d              = addr_q;
        cnt_d               = cnt_q;
        rsp_data_d          = rsp_data_q;
        err_d               = 1'b0;
        mem_we              = 1'b0;
        dbg.dbg_cmd_ready   = 1'b0;
        dbg.dbg_wdata_ready = 1'b0;
        dbg.dbg_rsp_valid   = 1'b0;
        unique case (st_q)
            StIdle: begin
                // live_q keeps cmd_ready low while reset is asserted.
                dbg.dbg_cmd_ready = live_q && !enable;
                if (dbg.dbg_cmd_ready && dbg.dbg_cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = dbg.dbg_cmd_addr[AW-1:0];
                        cnt_d  = dbg.dbg_cmd_len;
                        st_d   = dbg.dbg_cmd_write ? StWr : StRdRd;
                    end
                end
            end
            StWr: begin
                dbg.dbg_wdata_ready = !enable;
                if (enable) begin
                    st_d  = StIdle;
                    err_d = 1'b1;
                end else if (dbg.dbg_wdata_valid) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) st_d = StIdle;
                end
            end
            StRdRd: begin
                if (enable) begin
                    st_d  = StIdle;
                    err_d = 1'b1;
                end else begin
                    rsp_data_d = {1'b1, DBG_ADDR_W'(addr_q), rd_word[31:0]};
                    err_d      = rd_par_err;
                    st_d       = StRdRsp;
                end
            end
            StRdRsp: begin
                dbg.dbg_rsp_valid = 1'b1;
                if (enable) begin
                    st_d  = StIdle;
                    err_d = 1'b1;
                end else if (dbg.dbg_rsp_ready) begin
                    if (cnt_q == '0) begin
                        st_d = StIdle;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        st_d   = StRdRd;
                    end
                end
            end
            default: st_d = StIdle;
        endcase
    end

    assign dbg.dbg_rsp_data = rsp_data_q;
    assign dbg.dbg_err      = err_q;
    assign dbg.dbg_busy     = (st_q != StIdle);
endmodule

// File: tb/tb_instr_mem_dbg_burst.sv
// Self-checking bench for instr_mem_dbg_burst: reference memory model plus response scoreboard.
module tb_instr_mem_dbg_burst;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] instr;
    logic        fetch_fault;

    int checks = 0;
    int passed = 0;
    logic [41:0] exp_q[$];
    logic [31:0] model [256];

    instr_mem_dbg_burst_if #(.DBG_ADDR_W(9), .LEN_W(8)) dbg_if ();

    instr_mem_dbg_burst #(
        .DEPTH(256), .DBG_ADDR_W(9), .LEN_W(8), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .stall(stall), .flush(flush),
        .pc(pc), .instr(instr), .fetch_fault(fetch_fault), .dbg(dbg_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [8:0] a, input logic [7:0] l);
        int n = 0;
        dbg_if.dbg_cmd_valid = 1'b1;
        dbg_if.dbg_cmd_write = wr;
        dbg_if.dbg_cmd_addr  = a;
        dbg_if.dbg_cmd_len   = l;
        while (!dbg_if.dbg_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (dbg_if.dbg_cmd_ready !== 1'b1)
            $display("FAIL cmd_accept: cmd_ready=%b required 1", dbg_if.dbg_cmd_ready);
        else passed++;
        tick();
        dbg_if.dbg_cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [8:0] a, input int nb, input logic [31:0] base);
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            dbg_if.dbg_wdata_valid = 1'b1;
            dbg_if.dbg_wdata = base + 32'(i);
            while (!dbg_if.dbg_wdata_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                checks++;
                $display("FAIL wdata_timeout: beat %0d never accepted, required ready", i);
            end
            model[(int'(a) + i) % 256] = base + 32'(i);
            tick();
        end
        dbg_if.dbg_wdata_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [8:0] a, input logic [7:0] l, input logic [31:0] base);
        send_cmd(1'b1, a, l);
        write_beats(a, int'(l) + 1, base);
    endtask

    task automatic collect(input int nbeats, input int hold);
        int got = 0;
        int cyc = 0;
        logic [41:0] held;
        logic [41:0] exp;
        dbg_if.dbg_rsp_ready = (hold == 0);
        while (got < nbeats && cyc < 200) begin
            if (dbg_if.dbg_rsp_valid && !dbg_if.dbg_rsp_ready) begin
                held = dbg_if.dbg_rsp_data;
                for (int k = 0; k < hold; k++) begin
                    tick();
                    checks++;
                    if (dbg_if.dbg_rsp_valid !== 1'b1 || dbg_if.dbg_rsp_data !== held)
                        $display("FAIL rsp_hold: valid=%b data=%h required valid=1 data=%h",
                                 dbg_if.dbg_rsp_valid, dbg_if.dbg_rsp_data, held);
                    else passed++;
                end
                dbg_if.dbg_rsp_ready = 1'b1;
            end else if (dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_extra: data=%h required no response", dbg_if.dbg_rsp_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (dbg_if.dbg_rsp_data !== exp)
                        $display("FAIL rsp_data: got %h required %h", dbg_if.dbg_rsp_data, exp);
                    else passed++;
                end
                got++;
                tick();
            end else begin
                tick();
            end
            cyc++;
        end
        if (got < nbeats) begin
            checks++;
            $display("FAIL rsp_timeout: got %0d beats required %0d", got, nbeats);
        end
        dbg_if.dbg_rsp_ready = 1'b0;
    endtask

    task automatic read_burst(input logic [8:0] a, input logic [7:0] l, input int hold);
        for (int i = 0; i <= int'(l); i++) begin
            int idx = (int'(a) + i) % 256;
            exp_q.push_back({1'b1, 9'(idx), model[idx]});
        end
        send_cmd(1'b0, a, l);
        collect(int'(l) + 1, hold);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (instr !== NOP) $display("FAIL rst_instr: got %h required %h", instr, NOP); else passed++;
        checks++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b required 0", fetch_fault); else passed++;
        checks++; if (dbg_if.dbg_cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b required 0", dbg_if.dbg_cmd_ready); else passed++;
        checks++; if (dbg_if.dbg_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b required 0", dbg_if.dbg_rsp_valid); else passed++;
        checks++; if (dbg_if.dbg_rsp_data !== 42'h0) $display("FAIL rst_rsp_data: got %h required 0", dbg_if.dbg_rsp_data); else passed++;
        checks++; if (dbg_if.dbg_err !== 1'b0) $display("FAIL rst_err: got %b required 0", dbg_if.dbg_err); else passed++;
        checks++; if (dbg_if.dbg_wdata_ready !== 1'b0) $display("FAIL rst_wready: got %b required 0", dbg_if.dbg_wdata_ready); else passed++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pc = 32'h0;
        tick();
        checks++; if (instr !== NOP) $display("FAIL post_rst_instr: got %h required %h", instr, NOP); else passed++;
        checks++; if (fetch_fault !== 1'b0) $display("FAIL post_rst_fault: got %b required 0", fetch_fault); else passed++;
        checks++; if (dbg_if.dbg_cmd_ready !== 1'b1) $display("FAIL post_rst_cmd_ready: got %b required 1", dbg_if.dbg_cmd_ready); else passed++;
    endtask

    task automatic test_wrap_burst();
        write_burst(9'h0FE, 8'd3, 32'hA000_0000);
        read_burst(9'h0FE, 8'd3, 0);
        checks++; if (dbg_if.dbg_busy !== 1'b0) $display("FAIL wrap_busy: got %b required 0", dbg_if.dbg_busy); else passed++;
    endtask

    task automatic test_backpressure();
        read_burst(9'h0FE, 8'd1, 5);
    endtask

    task automatic test_fetch();
        write_burst(9'h002, 8'd1, 32'hB000_0000);
        enable = 1'b1;
        pc = 32'h8;
        tick();
        checks++; if (instr !== model[2] || fetch_fault !== 1'b0) $display("FAIL fetch_pc8: got %h/%b required %h/0", instr, fetch_fault, model[2]); else passed++;
        checks++; if (dbg_if.dbg_cmd_ready !== 1'b0) $display("FAIL cmd_ready_running: got %b required 0", dbg_if.dbg_cmd_ready); else passed++;
        stall = 1'b1;
        pc = 32'hC;
        tick();
        checks++; if (instr !== model[2]) $display("FAIL fetch_stall: got %h required %h", instr, model[2]); else passed++;
        flush = 1'b1;
        tick();
        checks++; if (instr !== NOP || fetch_fault !== 1'b0) $display("FAIL fetch_flush: got %h/%b required %h/0", instr, fetch_fault, NOP); else passed++;
        flush = 1'b0;
        stall = 1'b0;
        pc = 32'h6;
        tick();
        checks++; if (instr !== NOP || fetch_fault !== 1'b1) $display("FAIL fetch_misalign: got %h/%b required %h/1", instr, fetch_fault, NOP); else passed++;
        pc = 32'h400;
        tick();
        checks++; if (instr !== NOP || fetch_fault !== 1'b1) $display("FAIL fetch_range: got %h/%b required %h/1", instr, fetch_fault, NOP); else passed++;
        stall = 1'b1;
        pc = 32'hC;
        tick();
        checks++; if (fetch_fault !== 1'b1) $display("FAIL fetch_stall_fault: got %b required 1", fetch_fault); else passed++;
        stall = 1'b0;
        tick();
        checks++; if (instr !== model[3] || fetch_fault !== 1'b0) $display("FAIL fetch_pcC: got %h/%b required %h/0", instr, fetch_fault, model[3]); else passed++;
        pc = 32'h3FC;
        tick();
        checks++; if (instr !== model[255] || fetch_fault !== 1'b0) $display("FAIL fetch_last: got %h/%b required %h/0", instr, fetch_fault, model[255]); else passed++;
        enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        write_burst(9'h000, 8'd7, 32'hC000_0000);
        send_cmd(1'b1, 9'h000, 8'd7);
        write_beats(9'h000, 3, 32'hD000_0000);
        checks++; if (dbg_if.dbg_busy !== 1'b1) $display("FAIL abort_busy_before: got %b required 1", dbg_if.dbg_busy); else passed++;
        enable = 1'b1;
        tick();
        checks++; if (dbg_if.dbg_err !== 1'b1) $display("FAIL abort_err: got %b required 1", dbg_if.dbg_err); else passed++;
        checks++; if (dbg_if.dbg_busy !== 1'b0) $display("FAIL abort_idle: got %b required 0", dbg_if.dbg_busy); else passed++;
        tick();
        checks++; if (dbg_if.dbg_err !== 1'b0) $display("FAIL abort_err_pulse: got %b required 0", dbg_if.dbg_err); else passed++;
        enable = 1'b0;
        tick();
        read_burst(9'h000, 8'd7, 0);
    endtask

    task automatic test_bad_addr();
        send_cmd(1'b1, 9'h100, 8'd0);
        checks++; if (dbg_if.dbg_err !== 1'b1) $display("FAIL badaddr_err: got %b required 1", dbg_if.dbg_err); else passed++;
        checks++; if (dbg_if.dbg_busy !== 1'b0) $display("FAIL badaddr_idle: got %b required 0", dbg_if.dbg_busy); else passed++;
        dbg_if.dbg_wdata_valid = 1'b1;
        dbg_if.dbg_wdata = 32'hDEAD_BEEF;
        checks++; if (dbg_if.dbg_wdata_ready !== 1'b0) $display("FAIL badaddr_wready: got %b required 0", dbg_if.dbg_wdata_ready); else passed++;
        tick();
        dbg_if.dbg_wdata_valid = 1'b0;
        checks++; if (dbg_if.dbg_err !== 1'b0) $display("FAIL badaddr_err_pulse: got %b required 0", dbg_if.dbg_err); else passed++;
        read_burst(9'h000, 8'd0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = NOP;
        dbg_if.dbg_cmd_valid   = 1'b0;
        dbg_if.dbg_cmd_write   = 1'b0;
        dbg_if.dbg_cmd_addr    = '0;
        dbg_if.dbg_cmd_len     = '0;
        dbg_if.dbg_wdata_valid = 1'b0;
        dbg_if.dbg_wdata       = '0;
        dbg_if.dbg_rsp_ready   = 1'b0;
        test_reset();
        test_wrap_burst();
        test_backpressure();
        test_fetch();
        test_abort();
        test_bad_addr();
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
